// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcode encodings, FSM state type and opcode classification
// for the sequential ALU slice.
package alu_seq_pkg;

    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] OP_ADD  = 4'd0;
    localparam logic [OPW-1:0] OP_SUB  = 4'd1;
    localparam logic [OPW-1:0] OP_INC  = 4'd2;
    localparam logic [OPW-1:0] OP_DEC  = 4'd3;
    localparam logic [OPW-1:0] OP_AND  = 4'd4;
    localparam logic [OPW-1:0] OP_OR   = 4'd5;
    localparam logic [OPW-1:0] OP_XOR  = 4'd6;
    localparam logic [OPW-1:0] OP_ASR1 = 4'd7;
    localparam logic [OPW-1:0] OP_ASRN = 4'd8;
    localparam logic [OPW-1:0] OP_MUL  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // An op needs the iterative datapath if it is MUL or an ASRN with a non-zero shift.
    function automatic logic is_multi(input logic [OPW-1:0] op, input logic shift_nz);
        return (op == OP_MUL) || ((op == OP_ASRN) && shift_nz);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand-side and result-side handshakes of alu_seq.
//   master: operand source / result consumer (drives in_valid, a, b, op, out_ready)
//   slave : the ALU (drives in_ready, out_valid, result, carry, zero, neg, ovf, busy)
interface alu_seq_if #(
    parameter int unsigned WIDTH = 4
);
    import alu_seq_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry, zero, neg, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry, zero, neg, ovf, busy
    );

endinterface

// File: rtl/alu_seq_core.sv
// alu_seq_core: combinational single-cycle ops (ADD..ASR1) and their flags.
//   a, b, op  : operands and opcode
//   result_c  : op result; ASRN returns a unchanged (the zero-shift case),
//               MUL and reserved opcodes return 0
//   carry_c, zero_c, neg_c, ovf_c : flags; all 0 for opcodes not handled here
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] result_c,
    output logic             carry_c,
    output logic             zero_c,
    output logic             neg_c,
    output logic             ovf_c
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic           known;

    // Opcode decode; SUB/DEC carry is the no-borrow bit of a + ~b + 1.
    always_comb begin
        sum      = '0;
        result_c = '0;
        carry_c  = 1'b0;
        ovf_c    = 1'b0;
        known    = 1'b1;
        case (op)
            OP_ADD: begin
                sum      = {1'b0, a} + {1'b0, b};
                result_c = sum[MSB:0];
                carry_c  = sum[WIDTH];
                ovf_c    = (a[MSB] == b[MSB]) && (result_c[MSB] != a[MSB]);
            end
            OP_SUB: begin
                sum      = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                result_c = sum[MSB:0];
                carry_c  = sum[WIDTH];
                ovf_c    = (a[MSB] != b[MSB]) && (result_c[MSB] != a[MSB]);
            end
            OP_INC: begin
                sum      = {1'b0, a} + (WIDTH+1)'(1);
                result_c = sum[MSB:0];
                carry_c  = sum[WIDTH];
                ovf_c    = !a[MSB] && result_c[MSB];
            end
            OP_DEC: begin
                sum      = {1'b0, a} + {1'b0, {WIDTH{1'b1}}};
                result_c = sum[MSB:0];
                carry_c  = sum[WIDTH];
                ovf_c    = a[MSB] && !result_c[MSB];
            end
            OP_AND:  result_c = a & b;
            OP_OR:   result_c = a | b;
            OP_XOR:  result_c = a ^ b;
            OP_ASR1: begin
                result_c = {a[MSB], a[MSB:1]};
                carry_c  = a[0];
            end
            OP_ASRN: result_c = a;
            default: known = 1'b0;
        endcase
        zero_c = known && (result_c == '0);
        neg_c  = result_c[MSB];
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with valid/ready on both sides. Single-cycle ops complete
// one cycle after accept; ASRN (n>0) shifts one bit per cycle and MUL runs a
// WIDTH-step unsigned shift-add, both through the BUSY state.
//   clk, rst : clock and synchronous active-high reset
//   bus      : alu_seq_if.slave (operand handshake, result handshake, flags, busy)
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = SHW + 1;
    localparam int unsigned MSB = WIDTH - 1;

    state_t             state;
    state_t             state_nxt;

    logic [OPW-1:0]     op_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CW-1:0]      cnt_q;

    logic [WIDTH-1:0]   result_q;
    logic               carry_q;
    logic               zero_q;
    logic               neg_q;
    logic               ovf_q;

    logic [WIDTH-1:0]   core_result;
    logic               core_carry;
    logic               core_zero;
    logic               core_neg;
    logic               core_ovf;

    logic               in_ready_c;
    logic               accept_c;
    logic               multi_c;
    logic               last_c;
    logic [WIDTH-1:0]   asr_nxt_c;
    logic [2*WIDTH-1:0] prod_nxt_c;

    alu_seq_core #(.WIDTH(WIDTH)) u_core (
        .a        (bus.a),
        .b        (bus.b),
        .op       (bus.op),
        .result_c (core_result),
        .carry_c  (core_carry),
        .zero_c   (core_zero),
        .neg_c    (core_neg),
        .ovf_c    (core_ovf)
    );

    // Handshake and iteration helpers.
    assign in_ready_c = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready));
    assign accept_c   = bus.in_valid && in_ready_c;
    assign multi_c    = is_multi(bus.op, |bus.b[SHW-1:0]);
    assign last_c     = (cnt_q == CW'(1));
    assign asr_nxt_c  = {opnd_q[MSB], opnd_q[MSB:1]};
    assign prod_nxt_c = prod_q + (opnd_q[0] ? mcand_q : '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE may chain straight into a new op when the result is taken.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept_c) state_nxt = multi_c ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: begin
                if (last_c) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (accept_c)           state_nxt = multi_c ? ST_BUSY : ST_DONE;
                else if (bus.out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, iterative datapath and result/flag registers.
    // opnd_q holds the value being shifted for ASRN and the multiplier for MUL.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            opnd_q   <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept_c) begin
            op_q    <= bus.op;
            opnd_q  <= (bus.op == OP_MUL) ? bus.b : bus.a;
            mcand_q <= {{WIDTH{1'b0}}, bus.a};
            prod_q  <= '0;
            cnt_q   <= (bus.op == OP_MUL) ? CW'(WIDTH) : CW'(bus.b[SHW-1:0]);
            if (!multi_c) begin
                result_q <= core_result;
                carry_q  <= core_carry;
                zero_q   <= core_zero;
                neg_q    <= core_neg;
                ovf_q    <= core_ovf;
            end
        end else if (state == ST_BUSY) begin
            cnt_q   <= cnt_q - CW'(1);
            mcand_q <= mcand_q << 1;
            prod_q  <= prod_nxt_c;
            opnd_q  <= (op_q == OP_MUL) ? (opnd_q >> 1) : asr_nxt_c;
            if (last_c) begin
                ovf_q <= 1'b0;
                if (op_q == OP_MUL) begin
                    result_q <= prod_nxt_c[MSB:0];
                    carry_q  <= |prod_nxt_c[2*WIDTH-1:WIDTH];
                    zero_q   <= (prod_nxt_c[MSB:0] == '0);
                    neg_q    <= prod_nxt_c[MSB];
                end else begin
                    result_q <= asr_nxt_c;
                    carry_q  <= opnd_q[0];
                    zero_q   <= (asr_nxt_c == '0);
                    neg_q    <= asr_nxt_c[MSB];
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state == ST_BUSY);
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;

endmodule
